// File: rtl/falafel_pkg.sv
// Shared falafel LSU/memory types: data width, the empty-slot key and the request format.
package falafel_pkg;

  localparam int DATA_W = 32;

  // Value a CAS must find in a word before it is allowed to swap.
  localparam logic [DATA_W-1:0] EMPTY_KEY = '0;

  typedef enum logic [1:0] {
    MEM_LOAD,
    MEM_STORE,
    MEM_CAS
  } mem_op_e;

  typedef struct packed {
    mem_op_e           op;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } mem_req_t;

  // CAS takes priority over the store flag.
  function automatic mem_op_e decode_op(input logic is_write, input logic is_cas);
    if (is_cas) begin
      return MEM_CAS;
    end
    return is_write ? MEM_STORE : MEM_LOAD;
  endfunction

endpackage

// File: rtl/falafel_mem_array.sv
// Single-port word array: synchronous write, asynchronous read.
module falafel_mem_array
  import falafel_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we) begin
      mem[idx] <= wdata;
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/falafel_mem_responder.sv
// Single-outstanding load/store/CAS responder with fixed latency over a cleared word array.
// Optional random backpressure on both handshakes when FALAFEL_MEM_STALL_EN is defined.
module falafel_mem_responder
  import falafel_pkg::*;
#(
  parameter int                DEPTH      = 1024,
  parameter int                LATENCY    = 2,
  parameter logic [DATA_W-1:0] FILL_VALUE = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              mem_req_val_i,
  output logic              mem_req_rdy_o,
  input  logic              mem_req_is_write_i,
  input  logic              mem_req_is_cas_i,
  input  logic [DATA_W-1:0] mem_req_addr_i,
  input  logic [DATA_W-1:0] mem_req_data_i,
  output logic              mem_rsp_val_o,
  input  logic              mem_rsp_rdy_i,
  output logic [DATA_W-1:0] mem_rsp_data_o
);

  localparam int IDX_W    = $clog2(DEPTH);
  localparam int ADDR_LSB = $clog2(DATA_W / 8);
  localparam int CNT_W    = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

  state_e            state_reg, state_next;
  logic [IDX_W-1:0]  clr_idx_reg, clr_idx_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [DATA_W-1:0] rsp_data_reg, rsp_data_next;

  mem_req_t          req;
  logic [IDX_W-1:0]  req_idx;
  logic              accept;
  logic              req_rdy;
  logic              rsp_val;

  logic              arr_we;
  logic [IDX_W-1:0]  arr_idx;
  logic [DATA_W-1:0] arr_wdata;
  logic [DATA_W-1:0] arr_rdata;

  assign req = '{op:   decode_op(mem_req_is_write_i, mem_req_is_cas_i),
                 addr: mem_req_addr_i,
                 data: mem_req_data_i};

  // Dropping low bits and truncating makes addresses wrap modulo DEPTH words.
  assign req_idx = IDX_W'(req.addr >> ADDR_LSB);

`ifdef FALAFEL_MEM_STALL_EN
  logic [15:0] lfsr_reg;
  logic        rsp_raised_reg;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lfsr_reg       <= 16'hACE1;
      rsp_raised_reg <= 1'b0;
    end else begin
      lfsr_reg       <= {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
      rsp_raised_reg <= rsp_val & ~mem_rsp_rdy_i;
    end
  end

  // A response that has been shown stays up until taken.
  assign req_rdy = (state_reg == ST_IDLE) && (lfsr_reg[1:0] != 2'b00);
  assign rsp_val = (state_reg == ST_RESP) && (rsp_raised_reg || (lfsr_reg[3:2] != 2'b00));
`else
  assign req_rdy = (state_reg == ST_IDLE);
  assign rsp_val = (state_reg == ST_RESP);
`endif

  assign accept = mem_req_val_i & req_rdy;

  falafel_mem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk_i (clk_i),
    .we    (arr_we),
    .idx   (arr_idx),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

  always_comb begin
    state_next    = state_reg;
    clr_idx_next  = clr_idx_reg;
    cnt_next      = cnt_reg;
    rsp_data_next = rsp_data_reg;
    arr_we        = 1'b0;
    arr_idx       = req_idx;
    arr_wdata     = req.data;

    case (state_reg)
      ST_CLEAR: begin
        arr_we    = 1'b1;
        arr_idx   = clr_idx_reg;
        arr_wdata = FILL_VALUE;
        if (clr_idx_reg == IDX_W'(DEPTH - 1)) begin
          clr_idx_next = '0;
          state_next   = ST_IDLE;
        end else begin
          clr_idx_next = clr_idx_reg + 1'b1;
        end
      end

      ST_IDLE: begin
        if (accept) begin
          case (req.op)
            MEM_STORE: begin
              arr_we        = 1'b1;
              rsp_data_next = '0;
            end
            MEM_CAS: begin
              if (arr_rdata == EMPTY_KEY) begin
                arr_we        = 1'b1;
                rsp_data_next = '0;
              end else begin
                rsp_data_next = {{(DATA_W-1){1'b0}}, 1'b1};
              end
            end
            default: rsp_data_next = arr_rdata;
          endcase
          cnt_next   = CNT_W'(LATENCY - 1);
          state_next = (LATENCY == 1) ? ST_RESP : ST_WAIT;
        end
      end

      ST_WAIT: begin
        cnt_next = cnt_reg - 1'b1;
        if (cnt_reg <= CNT_W'(1)) begin
          state_next = ST_RESP;
        end
      end

      ST_RESP: begin
        if (rsp_val && mem_rsp_rdy_i) begin
          state_next = ST_IDLE;
        end
      end

      default: state_next = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg    <= ST_CLEAR;
      clr_idx_reg  <= '0;
      cnt_reg      <= '0;
      rsp_data_reg <= '0;
    end else begin
      state_reg    <= state_next;
      clr_idx_reg  <= clr_idx_next;
      cnt_reg      <= cnt_next;
      rsp_data_reg <= rsp_data_next;
    end
  end

  assign mem_req_rdy_o  = req_rdy;
  assign mem_rsp_val_o  = rsp_val;
  assign mem_rsp_data_o = rsp_data_reg;

endmodule
